// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder
// Receive side of the 7-segment display path. Active-low segment patterns
// arrive one digit per strobe. Each pattern is decoded back to a 4-bit digit,
// and the digits are assembled into a NUM_DIGITS-wide frame. The first digit
// received (HEX0) goes into the lowest nibble. The completed frame is offered
// downstream on a valid/ready handshake.
// The partial frame is assembled in a private buffer. bcd_out therefore only
// ever shows a complete frame.

module seg_frame_decoder #(
    parameter int NUM_DIGITS = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    input  logic                    seg_sof,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_err,
    output logic                    abort,
    output logic                    overrun
);

    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int FW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_DIGITS - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    // Decode result is {error, digit}.
    // Unknown patterns decode to E and flag the error.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0110001: r = {1'b0, 4'h4};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0011000: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    state_t          state_q;
    logic [FW-1:0]   frame_q;
    logic [FW-1:0]   bcd_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   timer_q;
    logic            acc_err_q;
    logic            frame_err_q;
    logic            out_valid_q;
    logic            abort_q;
    logic            overrun_q;

    logic [4:0]      dec_s;
    logic [3:0]      dig_s;
    logic            dig_err_s;
    logic [FW-1:0]   frame_d;
    logic [FW-1:0]   sof_frame_s;
    logic            start_s;

    // Decode the incoming pattern and build candidate frame contents.
    always_comb begin
        dec_s       = seg_decode(seg_in);
        dig_s       = dec_s[3:0];
        dig_err_s   = dec_s[4];
        sof_frame_s = '0;
        sof_frame_s[3:0] = dig_s;
        frame_d     = frame_q;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (cnt_q == CW'(k)) begin
                frame_d[4*k +: 4] = dig_s;
            end else begin
                frame_d[4*k +: 4] = frame_q[4*k +: 4];
            end
        end
        // A start-of-frame is honoured in IDLE and COLLECT.
        // In HOLD it is honoured only when it coincides with the accept.
        start_s = seg_valid && seg_sof && ((state_q != S_HOLD) || out_ready);
    end

    // Frame assembly FSM with registered outputs.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            timer_q     <= '0;
            acc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            out_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            if (start_s) begin
                timer_q <= '0;
                if (NUM_DIGITS == 1) begin
                    bcd_q       <= sof_frame_s;
                    frame_err_q <= dig_err_s;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= S_HOLD;
                end else begin
                    frame_q     <= sof_frame_s;
                    acc_err_q   <= dig_err_s;
                    cnt_q       <= CW'(1);
                    out_valid_q <= 1'b0;
                    state_q     <= S_COLLECT;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        // Strobes without start-of-frame are ignored here.
                        timer_q <= '0;
                    end
                    S_COLLECT: begin
                        if (seg_valid) begin
                            timer_q <= '0;
                            if (cnt_q == LAST_IDX) begin
                                bcd_q       <= frame_d;
                                frame_err_q <= acc_err_q | dig_err_s;
                                out_valid_q <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= S_HOLD;
                            end else begin
                                frame_q   <= frame_d;
                                acc_err_q <= acc_err_q | dig_err_s;
                                cnt_q     <= cnt_q + CW'(1);
                            end
                        end else if (timer_q == TIMER_END) begin
                            // Partial frame is dropped; bcd_out keeps the last full frame.
                            abort_q <= 1'b1;
                            timer_q <= '0;
                            cnt_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                    S_HOLD: begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            state_q     <= S_IDLE;
                        end else if (seg_valid) begin
                            overrun_q <= 1'b1;
                        end else begin
                            overrun_q <= overrun_q;
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        timer_q     <= '0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bcd_out   = bcd_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign abort     = abort_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Scoreboard bench for seg_frame_decoder (4 digits, TIMEOUT=8).
// Inputs change on the falling edge. The monitor samples 1 ns before each
// rising edge. Each accepted frame is popped from the expected queue and
// compared.

module tb_seg_frame_decoder;

    localparam int ND = 4;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic [6:0]    seg_in;
    logic          seg_valid;
    logic          seg_sof;
    logic [4*ND-1:0] bcd_out;
    logic          out_valid;
    logic          out_ready;
    logic          frame_err;
    logic          abort;
    logic          overrun;

    int total = 0;
    int bad = 0;
    int delivered = 0;
    int abort_cnt = 0;
    int a0;
    logic [16:0] exp_q[$];

    // Segment patterns (g..a, active low).
    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000, P4A = 7'b0110001, P4B = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0011000, PBL = 7'b1111111;
    localparam logic [6:0] PBAD = 7'b0101010, PBAD2 = 7'b1111110;

    seg_frame_decoder #(.NUM_DIGITS(ND), .TIMEOUT(TO)) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .seg_in   (seg_in),
        .seg_valid(seg_valid),
        .seg_sof  (seg_sof),
        .bcd_out  (bcd_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .abort    (abort),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop and compare on every accepted frame.
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got=%0h expected=none at %0t", bcd_out, $time);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("frame_bcd", {16'h0, bcd_out}, {16'h0, e[15:0]});
                check("frame_err", {31'h0, frame_err}, {31'h0, e[16]});
                delivered++;
            end
        end
    end

    // Count abort pulses (one sample per cycle).
    always begin
        @(negedge clk);
        #4;
        if (abort) abort_cnt++;
    end

    // Called at a falling edge; returns at the next falling edge.
    task automatic strobe(input logic [6:0] s, input logic sof);
        seg_in    = s;
        seg_valid = 1'b1;
        seg_sof   = sof;
        @(negedge clk);
        seg_valid = 1'b0;
        seg_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        strobe(s0, 1'b1);
        strobe(s1, 1'b0);
        strobe(s2, 1'b0);
        strobe(s3, 1'b0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seg_in = 7'h7F; seg_valid = 1'b0; seg_sof = 1'b0; out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_bcd", {16'h0, bcd_out}, 32'd0);
        check("rst_flags", {29'h0, frame_err, abort, overrun}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic frame, latency and return to idle
        exp_q.push_back({1'b0, 16'h6526});
        strobe(P6, 1'b1); strobe(P2, 1'b0); strobe(P5, 1'b0);
        check("t1_not_early", {31'h0, out_valid}, 32'd0);
        strobe(P6, 1'b0);
        check("t1_latency", {31'h0, out_valid}, 32'd1);
        @(negedge clk);
        check("t1_idle", {31'h0, out_valid}, 32'd0);
        wait_drain();

        // 2: both encodings of 4 plus blank
        exp_q.push_back({1'b0, 16'hF441});
        send_frame(P1, P4A, P4B, PBL);
        wait_drain();

        // 3: undecodable pattern in position 2
        exp_q.push_back({1'b1, 16'h9E30});
        send_frame(P0, P3, PBAD, P9);
        wait_drain();

        // 4a: timeout abort
        a0 = abort_cnt;
        strobe(P7, 1'b1);
        repeat (12) @(negedge clk);
        check("t4_abort_once", abort_cnt - a0, 32'd1);
        check("t4_bcd_kept", {16'h0, bcd_out}, 32'h9E30);
        check("t4_no_valid", {31'h0, out_valid}, 32'd0);
        exp_q.push_back({1'b0, 16'h2189});
        send_frame(P9, P8, P1, P2);
        wait_drain();
        // 4b: restart mid-frame
        exp_q.push_back({1'b0, 16'h8765});
        strobe(P0, 1'b1); strobe(P1, 1'b0);
        send_frame(P5, P6, P7, P8);
        wait_drain();

        // 5: overrun while held, then accept with simultaneous sof
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 16'h0123});
        send_frame(P3, P2, P1, P0);
        check("t5_valid", {31'h0, out_valid}, 32'd1);
        check("t5_no_ovr_yet", {31'h0, overrun}, 32'd0);
        strobe(P8, 1'b1); strobe(P9, 1'b0);
        check("t5_overrun", {31'h0, overrun}, 32'd1);
        check("t5_bcd_stable", {16'h0, bcd_out}, 32'h0123);
        check("t5_still_valid", {31'h0, out_valid}, 32'd1);
        exp_q.push_back({1'b0, 16'h051F});
        out_ready = 1'b1;
        strobe(PBL, 1'b1); strobe(P1, 1'b0); strobe(P5, 1'b0); strobe(P0, 1'b0);
        wait_drain();
        check("t5_sticky", {31'h0, overrun}, 32'd1);

        // 6a: async reset in COLLECT
        strobe(P0, 1'b1); strobe(P1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t6a_bcd", {16'h0, bcd_out}, 32'd0);
        check("t6a_flags", {28'h0, out_valid, frame_err, abort, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // 6b: async reset in HOLD
        out_ready = 1'b0;
        send_frame(P0, PBAD2, P0, P0);
        check("t6b_valid", {31'h0, out_valid}, 32'd1);
        check("t6b_err", {31'h0, frame_err}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6b_bcd", {16'h0, bcd_out}, 32'd0);
        check("t6b_flags", {28'h0, out_valid, frame_err, abort, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        exp_q.push_back({1'b0, 16'h2647});
        send_frame(P7, P4B, P6, P2);
        wait_drain();

        repeat (3) @(negedge clk);
        check("delivered", delivered, 32'd8);
        check("abort_total", abort_cnt, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_frame_decoder.md
Name: seg_frame_decoder

Overview:
Receive side of the 7-segment display path. Takes a stream of active-low segment patterns, one digit per strobe, in the same encoding the display encoder produces. Decodes each pattern back to a 4-bit digit and assembles a NUM_DIGITS frame. Presents the frame on a valid/ready handshake to downstream checking or LEDR display logic.

Parameters:
NUM_DIGITS, 4, digits per frame (1..8); the first digit received is HEX0 and goes into the lowest nibble.
TIMEOUT, 1000, maximum idle cycles between strobes inside a frame before the partial frame is aborted (at least 2).

Ports:
CLOCK_50  in  1  system clock; all logic on the rising edge.
RESET_N  in  1  asynchronous active-low reset.
seg_in  in  7  active-low segment pattern; bit0 = segment a … bit6 = segment g.
seg_valid  in  1  strobe; seg_in is sampled on this cycle.
seg_sof  in  1  qualifies seg_valid; marks the first digit (HEX0) of a frame.
bcd_out  out  4*NUM_DIGITS  decoded frame; digit k occupies bits [4k+3:4k].
out_valid  out  1  frame available; held until accepted.
out_ready  in  1  downstream accept.
frame_err  out  1  at least one pattern in the frame was undecodable; valid while out_valid=1.
abort  out  1  one-cycle pulse when a partial frame times out.
overrun  out  1  sticky; a strobe arrived while in HOLD and was dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE, bcd_out=0, out_valid=0, frame_err=0, abort=0, overrun=0, digit counter=0, timer=0.
- Decode table, exact match on seg_in:
  - 1000000 → 0; 1111001 → 1; 0100100 → 2; 0110000 → 3.
  - 0110001 → 4; 0011001 → 4 (both encodings accepted).
  - 0010010 → 5; 0000010 → 6; 1111000 → 7; 0000000 → 8; 0011000 → 9.
  - 1111111 → F (blank, legal).
  - Any other pattern → E and sets the frame error accumulator.
- IDLE:
  - seg_valid & seg_sof: store digit 0, clear the error accumulator, counter=1, go to COLLECT. If NUM_DIGITS=1, go directly to HOLD.
  - seg_valid without seg_sof: ignored, no flags.
- COLLECT:
  - seg_valid & seg_sof: restart. The partial frame is discarded silently, the new digit is stored as digit 0, the accumulator is cleared, counter=1.
  - seg_valid & !seg_sof: store the digit at index counter. If counter = NUM_DIGITS-1, go to HOLD; otherwise counter+1.
  - Each strobe clears the timer. Otherwise the timer increments. When the timer reaches TIMEOUT-1: abort=1 for one cycle, go to IDLE, bcd_out unchanged.
- HOLD:
  - out_valid=1, registered, asserted the cycle after the last digit is sampled (latency 1).
  - bcd_out and frame_err are stable for the whole of HOLD.
  - bcd_out updates only on HOLD entry; it is never a partial frame.
  - out_valid & out_ready: deassert out_valid next cycle, go to IDLE.
  - A same-cycle seg_valid & seg_sof is accepted as the start of a new frame (go to COLLECT with counter=1, or to HOLD if NUM_DIGITS=1).
  - Any seg_valid in HOLD without a handshake that cycle is dropped and sets overrun. overrun clears only on reset.
- Timer does not run in IDLE or HOLD.
- Reset asserted mid-frame or in HOLD: immediate return to reset values; no out_valid or abort is emitted.

Test Plan:
1. Reset, then strobes 0000010(sof), 0100100, 0010010, 0000010, out_ready=1 → out_valid rises the cycle after the 4th strobe; bcd_out=16'h6526, frame_err=0; IDLE the next cycle.
2. Frame 1111001(sof), 0110001, 0011001, 1111111 → bcd_out=16'hF441, frame_err=0.
3. Frame containing pattern 0101010 in position 2 → that nibble = E, frame_err=1; other nibbles decoded normally.
4. TIMEOUT=8: sof strobe followed by 8 idle cycles → abort pulses exactly once, no out_valid; the next sof frame decodes correctly. Also: sof strobe mid-frame → restart, only the new frame is delivered.
5. Hold out_ready=0 after a frame, send 2 strobes → overrun=1, bcd_out unchanged. Then out_ready=1 with a simultaneous sof → the new frame is collected and delivered.
6. Assert RESET_N low asynchronously in COLLECT and in HOLD → all outputs 0 without waiting for a clock edge; the subsequent frame decodes normally.
